lcg_stim_gen: RTL

Synthesizable, parametrised stimulus source for the fuzz harness. It generates OUT_W-bit input vectors for a DUT's flat input bus, using the harness's 32-bit LCG fill order. Unlike a bench-only generator, it has a run-length counter, a valid/ready output handshake, runtime seed load, abort, and a walking-one mode. It sits between harness control and the DUT input bus, in either an emulation or a simulation top.

---
 rtl/lcg_stim_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lcg_stim_gen.sv
// Stimulus source for the fuzz harness: fills OUT_W-bit vectors one 32-bit LCG chunk per cycle
// (or with a walking one) and presents them on a valid/ready handshake for a fixed-length run.
module lcg_stim_gen #(
    parameter int          OUT_W        = 335,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] SEED_DEFAULT = 32'd767950141
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cycles,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    output logic [OUT_W-1:0] vec,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);

    localparam int          N_CHUNKS = (OUT_W + 31) / 32;
    localparam int          CHK_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int          WALK_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [31:0] LCG_MUL  = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC  = 32'h3039;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [31:0]        r_rng;
    logic [OUT_W-1:0]   r_vec;
    logic               r_valid;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cycles;
    logic               r_mode_walk;
    logic [WALK_W-1:0]  r_walk_pos;
    logic [CHK_W-1:0]   r_chunk;
    logic               r_busy;
    logic               r_done;

    logic [31:0]        w_rng_next;
    logic               w_last_chunk;
    logic               w_last_vec;

    assign w_rng_next   = r_rng * LCG_MUL + LCG_INC;
    assign w_last_chunk = (r_chunk == CHK_W'(N_CHUNKS - 1));
    assign w_last_vec   = (r_idx == r_cycles - CNT_W'(1));

    // NOTE: every register below is updated with <= so all next-state terms see this cycle's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rng       <= SEED_DEFAULT;
            r_vec       <= '0;
            r_valid     <= 1'b0;
            r_idx       <= '0;
            r_cycles    <= '0;
            r_mode_walk <= 1'b0;
            r_walk_pos  <= '0;
            r_chunk     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (seed_load) begin
                        r_rng <= seed_in;
                    end
                    if (start) begin
                        if (cycles == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cycles    <= cycles;
                            r_mode_walk <= (mode == 2'd1);
                            r_idx       <= '0;
                            r_walk_pos  <= '0;
                            r_chunk     <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (!r_mode_walk) begin
                            r_rng <= w_rng_next;
                        end
                        // Only the bits of the current chunk are rewritten; the loop unrolls to per-bit enables.
                        for (int i = 0; i < OUT_W; i++) begin
                            if (r_chunk == CHK_W'(i / 32)) begin
                                r_vec[i] <= r_mode_walk ? (r_walk_pos == WALK_W'(i))
                                                        : w_rng_next[i % 32];
                            end
                        end
                        if (w_last_chunk) begin
                            r_valid <= 1'b1;
                            r_state <= S_PRESENT;
                        end else begin
                            r_chunk <= r_chunk + CHK_W'(1);
                        end
                    end
                end

                S_PRESENT: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (vec_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_vec) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx      <= r_idx + CNT_W'(1);
                            r_walk_pos <= (r_walk_pos == WALK_W'(OUT_W - 1)) ? '0
                                                                             : r_walk_pos + WALK_W'(1);
                            r_chunk    <= '0;
                            r_state    <= S_FILL;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vec       = r_vec;
    assign vec_valid = r_valid;
    assign vec_idx   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
